// File: rtl/dsp_pkg.sv
// Shared definitions for the windowed accumulate-and-dump path.
//   state_t    : accumulator FSM states (IDLE / ACCUM / HOLD)
//   DATA_W_DEF : default product sample width
//   WINDOW_DEF : default samples per window
//   ACC_W_DEF  : default accumulator / result width
package dsp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 12;
    localparam int WINDOW_DEF = 16;
    localparam int ACC_W_DEF  = 16;

endpackage

// File: rtl/accumulate_dump_block_sat_add.sv
// sat_add: combinational ACC_W-bit signed adder for the window accumulator.
// Optional macro ACCUM_SAT_EN: when defined, results clamp to the signed
// range and o_ovf flags the clamp; otherwise the sum wraps and o_ovf is 0.
//   i_a, i_b : signed addends
//   o_sum    : signed result (clamped or wrapped)
//   o_ovf    : a clamp happened on this addition
module sat_add
    import dsp_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] i_a,
    input  logic signed [ACC_W-1:0] i_b,
    output logic signed [ACC_W-1:0] o_sum,
    output logic                    o_ovf
);

    logic signed [ACC_W-1:0] w_raw;

    assign w_raw = i_a + i_b;

`ifdef ACCUM_SAT_EN
    logic w_ovf;

    // Overflow only when both addends share a sign and the result does not.
    assign w_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);
    assign o_sum = !w_ovf        ? w_raw :
                   i_a[ACC_W-1]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                   {1'b0, {(ACC_W-1){1'b1}}};
    assign o_ovf = w_ovf;
`else
    assign o_sum = w_raw;
    assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/accumulate_dump_block.sv
// accumulate_dump_block: sums WINDOW valid product samples into a signed
// ACC_W accumulator and presents the total with a valid/ready handshake.
// The sample arriving on the handshake cycle opens the next window.
// Optional macro ACCUM_SAT_EN (inside sat_add): saturating additions and op_sat.
//   ip_clock : clock, posedge
//   ip_reset : asynchronous active-low reset
//   ip_data  : signed product sample
//   ip_valid : ip_data is a new sample
//   ip_clear : synchronous abort of the window, clears sticky flags
//   ip_ready : downstream accepts op_data
//   op_data  : registered window sum
//   op_valid : op_data holds a completed sum
//   op_busy  : window partially accumulated
//   op_drop  : sticky, sample arrived while result stalled
//   op_sat   : sticky, saturation occurred
module accumulate_dump_block
    import dsp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WINDOW = WINDOW_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     ip_clock,
    input  logic                     ip_reset,
    input  logic signed [DATA_W-1:0] ip_data,
    input  logic                     ip_valid,
    input  logic                     ip_clear,
    input  logic                     ip_ready,
    output logic signed [ACC_W-1:0]  op_data,
    output logic                     op_valid,
    output logic                     op_busy,
    output logic                     op_drop,
    output logic                     op_sat
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    state_t                  r_state, w_state_nxt;
    logic signed [ACC_W-1:0] r_acc,   w_acc_nxt;
    logic [CNT_W-1:0]        r_cnt,   w_cnt_nxt;
    logic signed [ACC_W-1:0] r_data,  w_data_nxt;
    logic                    r_valid, w_valid_nxt;
    logic                    r_drop,  w_drop_nxt;
    logic                    r_sat,   w_sat_nxt;

    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_ovf;

    assign w_ext = ACC_W'(ip_data);

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_ext),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge ip_clock or negedge ip_reset) begin
        if (!ip_reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_drop  <= w_drop_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_drop_nxt  = r_drop;
        w_sat_nxt   = r_sat;
        if (ip_clear) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_drop_nxt  = 1'b0;
            w_sat_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ip_valid) begin
                        w_acc_nxt   = w_ext;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    if (ip_valid) begin
                        w_acc_nxt = w_sum;
                        w_cnt_nxt = r_cnt + 1'b1;
                        w_sat_nxt = r_sat | w_ovf;
                        if (r_cnt == LAST) begin
                            w_data_nxt  = w_sum;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ip_ready) begin
                        w_valid_nxt = 1'b0;
                        if (ip_valid) begin
                            w_acc_nxt   = w_ext;
                            w_cnt_nxt   = CNT_W'(1);
                            w_state_nxt = ACCUM;
                        end else begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = IDLE;
                        end
                    end else if (ip_valid) begin
                        w_drop_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign op_data  = r_data;
    assign op_valid = r_valid;
    assign op_busy  = (r_state == ACCUM);
    assign op_drop  = r_drop;
    assign op_sat   = r_sat;

endmodule
